sdf_r2_stage_ctrl: RTL
======================

# sdf_r2_stage_ctrl

Parametrised control unit for one radix-2 single-path delay-feedback (SDF) FFT stage of N points. It sequences the fill, sum and difference phases and registers the input sample toward butterfly port A. It also drives the delay-line shift enable and supplies the quantised twiddle W_N^k. Unlike the fixed 16-point first-stage controller, it adds three behaviours: mid-frame input gaps (stall), an autonomous drain after the last frame, and frame markers.

## Interface
- N, 32: stage size in points; power of two, 4 to 1024; delay D = N/2
- DATA_W, 8: width of each real/imaginary data component
- TW_W, 8: twiddle width, signed, format Q2.(TW_W-2)
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- valid_i  in  1  input sample valid; one sample per cycle when high
- data_in_r, data_in_i  in  DATA_W each  input sample, signed
- valid_o  out  1  butterfly output valid (FIRST/SECOND steps only)
- shift_en_o  out  1  delay-line advance for this cycle
- state  out  2  phase of the sample on data_out: IDLE=0, FIRST=1, SECOND=2, FILL=3
- data_out_r, data_out_i  out  DATA_W each  registered input sample (butterfly port A)
- WN_r, WN_i  out  TW_W each  twiddle for the current SECOND step, else 0
- sop_o  out  1  first FIRST output of a frame
- eop_o  out  1  last SECOND output of a frame
- err_o  out  1  sticky: valid_i seen while draining; cleared only by reset

## Operation
- Step counter k: log2(D) bits, wraps at D-1. States: IDLE, FILL, FIRST, SECOND; internal drain flag.
- "advance" is the step condition. It equals valid_i in IDLE, FILL, FIRST, and in SECOND with drain=0. It equals 1 in SECOND with drain=1.
- IDLE: on valid_i, go to FILL with k=1. That sample is FILL step 0.
- FILL: on advance, k+1. At k=D-1 with advance, go to FIRST with k=0.
- FIRST: on advance, k+1. At k=D-1 with advance, go to SECOND with k=0 and drain=0.
- SECOND, first step: if valid_i, run in streaming mode; the incoming sample is step 0 of the next frame's first half. If not valid_i, set drain=1 and advance anyway.
- SECOND streaming: gaps stall k. At k=D-1 with advance, go to FIRST (the next frame is already filled).
- SECOND draining: k advances every cycle. At k=D-1, go to IDLE and clear drain. Any valid_i during drain sets err_o and the sample is dropped.
- Twiddle: W = cos(2πk/N) − j·sin(2πk/N), scaled by 2^(TW_W-2), rounded to nearest (ties away from zero). k=0 gives +1.0 = 0x40 at TW_W=8.

## Timing
- Every output is registered and updates the cycle after the step it describes. Latency from data_in to data_out is 1.
- data_out follows data_in every cycle, advance or not. state, WN, valid_o, sop_o and eop_o describe the sample on data_out.
- shift_en_o = registered advance. valid_o = registered (advance & state∈{FIRST,SECOND}).
- Stall cycle: valid_o=0, shift_en_o=0, k held, WN held.
- sop_o: FIRST with k=0 and advance. eop_o: SECOND with k=D-1 and advance.
- Back-to-back frames give 100% valid_o after the initial D-cycle fill.
- Reset (async, any time, including mid-frame): state=IDLE, k=0, drain=0, every output 0. The first advance is taken on the first clk edge after rst_n rises.

## Structure
- Shared FFT package holds the state encodings and the fixed-point helper constant for Q2.(TW_W-2) scaling.
- Sub-module sdf_twiddle_rom(N, TW_W): table of D entries, built at elaboration, read by k. Its output is registered inside the controller.

## Test plan
- N=32, 32 contiguous samples then idle:
  - valid_o low for 16 cycles, then high for 32; state 3, then 1×16, then 2×16.
  - One sop_o and one eop_o.
  - Back to IDLE 49 cycles after the first sample.
- Twiddle check, N=32, TW_W=8:
  - k=0 → (0x40,0x00)
  - k=1 → (0x3F,0xF4)
  - k=8 → (0x00,0xC0)
  - k=15 → (0xC1,0xF4)
- Three back-to-back frames: valid_o continuous from cycle 17 to end of drain; exactly 3 sop_o and 3 eop_o.
- valid_i low for 3 cycles at FIRST k=5: k held, valid_o and shift_en_o low for 3 cycles, WN unchanged; sequence resumes at k=6.
- valid_i pulsed at SECOND k=4 during drain: err_o rises and stays 1; drain still ends at k=15 in IDLE.
- rst_n pulsed low at FIRST k=9: all outputs 0 asynchronously. A new frame afterward behaves as in scenario 1. Repeat scenario 1 with N=8: fill 4, WN k=1 = (0x2D,0xD3).

Source files
------------

// File: rtl/sdf_r2_stage_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sdf_r2_stage_ctrl_pkg
// Shared definitions for the radix-2 SDF FFT stage controller:
//   - phase encodings reported on the controller's state output
//   - fixed-point constants used to build the Q2.(TW_W-2) twiddle table
// No ports (package).
// ---------------------------------------------------------------------------
package sdf_r2_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2,
    ST_FILL   = 2'd3
  } sdf_state_e;

  // Twiddles are Q2.(TW_W-2): two integer bits (sign + one) so +1.0 fits.
  localparam int TW_INT_BITS = 2;

  // Elaboration-time trig is evaluated in Q2.30 before rounding to TW_W.
  localparam int     CALC_FRAC = 30;
  localparam longint PI_CALC   = 64'sd3373259426;  // round(pi * 2^30)

  function automatic int tw_frac_bits(input int tw_w);
    return tw_w - TW_INT_BITS;
  endfunction

endpackage

// File: rtl/sdf_r2_stage_ctrl_if.sv
// ---------------------------------------------------------------------------
// sdf_r2_stage_ctrl_if
// Input sample stream of the SDF stage controller.
//   valid_i              one sample per cycle while high
//   data_in_r/data_in_i  signed sample components, DATA_W bits each
// Modports: master drives the stream (upstream / bench), slave receives it
// (the controller).
// ---------------------------------------------------------------------------
interface sdf_r2_stage_ctrl_if #(
  parameter int DATA_W = 8
) ();

  logic                     valid_i;
  logic signed [DATA_W-1:0] data_in_r;
  logic signed [DATA_W-1:0] data_in_i;

  modport master (output valid_i, output data_in_r, output data_in_i);
  modport slave  (input  valid_i, input  data_in_r, input  data_in_i);

endinterface

// File: rtl/sdf_twiddle_rom.sv
// ---------------------------------------------------------------------------
// sdf_twiddle_rom
// Combinational table of the D = N/2 twiddles W_N^k = cos(2*pi*k/N)
// - j*sin(2*pi*k/N) in Q2.(TW_W-2), rounded to nearest, ties away from zero.
// The table is computed at elaboration with integer Taylor series (angles
// folded into [0, pi/2]); nothing here is evaluated at run time.
//   k     in  log2(N/2)  table index
//   wn_r  out TW_W       real part, signed
//   wn_i  out TW_W       imaginary part, signed
// ---------------------------------------------------------------------------
module sdf_twiddle_rom
  import sdf_r2_stage_ctrl_pkg::*;
#(
  parameter int N    = 32,
  parameter int TW_W = 8,
  parameter int K_W  = $clog2(N / 2)
) (
  input  logic        [K_W-1:0]  k,
  output logic signed [TW_W-1:0] wn_r,
  output logic signed [TW_W-1:0] wn_i
);

  localparam int D = N / 2;
  localparam int Q = N / 4;

  function automatic longint sin_calc(input longint x);
    longint x2, term, acc;
    x2   = (x * x) >>> CALC_FRAC;
    term = x;
    acc  = x;
    for (int n = 1; n <= 9; n++) begin
      term = -(((term * x2) >>> CALC_FRAC) / longint'((2 * n) * (2 * n + 1)));
      acc  = acc + term;
    end
    return acc;
  endfunction

  function automatic longint cos_calc(input longint x);
    longint x2, term, acc;
    x2   = (x * x) >>> CALC_FRAC;
    term = longint'(1) <<< CALC_FRAC;
    acc  = term;
    for (int n = 1; n <= 9; n++) begin
      term = -(((term * x2) >>> CALC_FRAC) / longint'((2 * n - 1) * (2 * n)));
      acc  = acc + term;
    end
    return acc;
  endfunction

  // Q2.30 -> Q2.(TW_W-2), round half away from zero.
  function automatic longint round_tw(input longint v);
    longint mag, r;
    int     sh;
    sh  = CALC_FRAC - tw_frac_bits(TW_W);
    mag = (v < 0) ? -v : v;
    r   = (mag + (longint'(1) <<< (sh - 1))) >>> sh;
    return (v < 0) ? -r : r;
  endfunction

  // Angles past pi/2 fold as cos(pi - a) = -cos(a), sin(pi - a) = sin(a).
  // The quarter point is forced exact so it cannot round off zero / one.
  function automatic logic [TW_W-1:0] tw_re(input int idx);
    int     m;
    longint th, c;
    m  = (idx <= Q) ? idx : (D - idx);
    th = (2 * PI_CALC * m) / N;
    c  = (m == Q) ? 64'sd0 : cos_calc(th);
    if (idx > Q) c = -c;
    return TW_W'(round_tw(c));
  endfunction

  function automatic logic [TW_W-1:0] tw_im(input int idx);
    int     m;
    longint th, s;
    m  = (idx <= Q) ? idx : (D - idx);
    th = (2 * PI_CALC * m) / N;
    s  = (m == Q) ? (longint'(1) <<< CALC_FRAC) : sin_calc(th);
    return TW_W'(-round_tw(s));
  endfunction

  logic signed [TW_W-1:0] tab_r [D];
  logic signed [TW_W-1:0] tab_i [D];

  for (genvar g = 0; g < D; g++) begin : g_tab
    localparam logic [TW_W-1:0] RE = tw_re(g);
    localparam logic [TW_W-1:0] IM = tw_im(g);
    assign tab_r[g] = RE;
    assign tab_i[g] = IM;
  end

  assign wn_r = tab_r[k];
  assign wn_i = tab_i[k];

endmodule

// File: rtl/sdf_r2_stage_ctrl.sv
// ---------------------------------------------------------------------------
// sdf_r2_stage_ctrl
// Control unit of one radix-2 single-path delay-feedback FFT stage (N points,
// delay D = N/2). Sequences FILL -> FIRST -> SECOND, tolerates input gaps
// (stall), drains the last frame on its own, and flags frame boundaries.
//   clk, rst_n             clock, asynchronous active-low reset
//   in_if (slave)          valid_i, data_in_r, data_in_i input stream
//   valid_o                butterfly output valid (FIRST/SECOND steps)
//   shift_en_o             delay-line advance
//   state                  phase of the sample on data_out (IDLE/FIRST/SECOND/FILL)
//   data_out_r/_i          registered input sample (butterfly port A)
//   WN_r/WN_i              twiddle of the current SECOND step, else 0
//   sop_o / eop_o          first FIRST / last SECOND output of a frame
//   err_o                  sticky: a sample arrived while draining
// All outputs are registered and describe the step taken on the previous edge.
// ---------------------------------------------------------------------------
module sdf_r2_stage_ctrl
  import sdf_r2_stage_ctrl_pkg::*;
#(
  parameter int N      = 32,
  parameter int DATA_W = 8,
  parameter int TW_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sdf_r2_stage_ctrl_if.slave       in_if,
  output logic                     valid_o,
  output logic                     shift_en_o,
  output logic [1:0]               state,
  output logic signed [DATA_W-1:0] data_out_r,
  output logic signed [DATA_W-1:0] data_out_i,
  output logic signed [TW_W-1:0]   WN_r,
  output logic signed [TW_W-1:0]   WN_i,
  output logic                     sop_o,
  output logic                     eop_o,
  output logic                     err_o
);

  localparam int D   = N / 2;
  localparam int K_W = $clog2(D);

  sdf_state_e             st;
  logic [K_W-1:0]         k;
  logic                   drain;

  logic                   adv;
  logic                   sec;
  logic                   k_last;
  logic                   drain_start;
  sdf_state_e             step_state;
  logic signed [TW_W-1:0] rom_r;
  logic signed [TW_W-1:0] rom_i;

  sdf_twiddle_rom #(
    .N    (N),
    .TW_W (TW_W)
  ) u_rom (
    .k    (k),
    .wn_r (rom_r),
    .wn_i (rom_i)
  );

  // The first SECOND step always advances: with a sample it starts streaming
  // into the next frame, without one it starts the drain.
  always_comb begin
    sec         = (st == ST_SECOND);
    k_last      = (k == K_W'(D - 1));
    drain_start = sec & ~drain & (k == '0) & ~in_if.valid_i;
    adv         = in_if.valid_i | (sec & (drain | (k == '0)));
    step_state  = st;
    if (st == ST_IDLE && in_if.valid_i) step_state = ST_FILL;
  end

  // Stage p0 -> outputs: FSM step and registered per-sample outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_IDLE;
      k          <= '0;
      drain      <= 1'b0;
      valid_o    <= 1'b0;
      shift_en_o <= 1'b0;
      state      <= ST_IDLE;
      data_out_r <= '0;
      data_out_i <= '0;
      WN_r       <= '0;
      WN_i       <= '0;
      sop_o      <= 1'b0;
      eop_o      <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      data_out_r <= in_if.data_in_r;
      data_out_i <= in_if.data_in_i;
      state      <= step_state;
      shift_en_o <= adv;
      valid_o    <= adv & ((st == ST_FIRST) | sec);
      sop_o      <= adv & (st == ST_FIRST) & (k == '0);
      eop_o      <= adv & sec & k_last;
      err_o      <= err_o | (sec & drain & in_if.valid_i);

      // A SECOND stall keeps the last twiddle; outside SECOND the twiddle is 0.
      if (adv) begin
        WN_r <= sec ? rom_r : '0;
        WN_i <= sec ? rom_i : '0;
      end else if (!sec) begin
        WN_r <= '0;
        WN_i <= '0;
      end

      unique case (st)
        ST_IDLE: begin
          if (in_if.valid_i) begin
            st <= ST_FILL;
            k  <= K_W'(1);
          end
        end
        ST_FILL: begin
          if (adv) begin
            k <= k + K_W'(1);
            if (k_last) st <= ST_FIRST;
          end
        end
        ST_FIRST: begin
          if (adv) begin
            k <= k + K_W'(1);
            if (k_last) begin
              st    <= ST_SECOND;
              drain <= 1'b0;
            end
          end
        end
        ST_SECOND: begin
          if (adv) begin
            k <= k + K_W'(1);
            if (drain_start) drain <= 1'b1;
            if (k_last) begin
              st    <= drain ? ST_IDLE : ST_FIRST;
              drain <= 1'b0;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule
